// File: rtl/n64_joybus_pkg.sv
// n64_joybus_pkg: shared state codes, bit timing and command codes
// for the console-side Joybus master.
package n64_joybus_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE      = 4'd0;
  localparam state_t ST_TX_LOAD   = 4'd1;
  localparam state_t ST_TX_LOW    = 4'd2;
  localparam state_t ST_TX_HIGH   = 4'd3;
  localparam state_t ST_STOP_LOW  = 4'd4;
  localparam state_t ST_STOP_HIGH = 4'd5;
  localparam state_t ST_RX_WAIT   = 4'd6;
  localparam state_t ST_RX_SAMPLE = 4'd7;
  localparam state_t ST_RX_RISE   = 4'd8;
  localparam state_t ST_RX_STOP   = 4'd9;
  localparam state_t ST_FIN       = 4'd10;

  localparam int BIT0_LOW  = 3;
  localparam int BIT1_LOW  = 1;
  localparam int BIT_TOTAL = 4;
  localparam int STOP_LOW  = 1;
  localparam int STOP_HIGH = 2;
  localparam int SAMPLE_AT = 2;

  localparam logic [7:0] CMD_INFO  = 8'h00;
  localparam logic [7:0] CMD_STATE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_WRITE = 8'h03;
  localparam logic [7:0] CMD_RESET = 8'hFF;

  function automatic int us_to_cyc(input int us, input int per);
    return us * per;
  endfunction

endpackage

// File: rtl/n64_joybus_rx_sync.sv
// n64_joybus_rx_sync: joy_in synchroniser and edge detectors.
// JOYBUS_GLITCH_FILTER_EN adds a 3-sample majority filter.
module n64_joybus_rx_sync
  import n64_joybus_pkg::*;
(
  input  logic clock,
  input  logic reset_l,
  input  logic joy_in,
  output logic level,
  output logic fall,
  output logic rise
);

  logic s1;
  logic s2;
  logic prev;
  logic lvl;

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= joy_in;
      s2 <= s1;
    end
  end

`ifdef JOYBUS_GLITCH_FILTER_EN
  logic [1:0] hist;
  logic       filt;

  // a lone low (or high) sample never wins the vote
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      hist <= 2'b11;
      filt <= 1'b1;
    end else begin
      hist <= {hist[0], s2};
      filt <= (s2 & hist[0]) |
              (s2 & hist[1]) |
              (hist[0] & hist[1]);
    end
  end

  assign lvl = filt;
`else
  assign lvl = s2;
`endif

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) prev <= 1'b1;
    else          prev <= lvl;
  end

  assign level = lvl;
  assign fall  = prev & ~lvl;
  assign rise  = ~prev & lvl;

endmodule

// File: rtl/n64_joybus_host.sv
// n64_joybus_host: PIF-side Joybus master, command out / reply in.
// Optional input glitch filter: JOYBUS_GLITCH_FILTER_EN.
module n64_joybus_host
  import n64_joybus_pkg::*;
#(
  parameter int CLK_PER_US = 50,
  parameter int TIMEOUT_US = 100,
  parameter int LEN_W      = 6
) (
  input  logic             clock,
  input  logic             reset_l,
  input  logic             start,
  input  logic [LEN_W-1:0] tx_len,
  input  logic [LEN_W-1:0] rx_len,
  input  logic [7:0]       tx_data,
  output logic             tx_rd,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [LEN_W-1:0] rx_count,
  output logic             joy_oe,
  input  logic             joy_in
);

  localparam int TO_CYC = us_to_cyc(TIMEOUT_US, CLK_PER_US);
  localparam int TW     = $clog2(TO_CYC + 1);

  localparam logic [TW-1:0] ONE_T = TW'(1);
  localparam logic [TW-1:0] T_B0L =
    TW'(us_to_cyc(BIT0_LOW, CLK_PER_US) - 1);
  localparam logic [TW-1:0] T_B1L =
    TW'(us_to_cyc(BIT1_LOW, CLK_PER_US) - 1);
  localparam logic [TW-1:0] T_B0H =
    TW'(us_to_cyc(BIT_TOTAL - BIT0_LOW, CLK_PER_US) - 1);
  localparam logic [TW-1:0] T_B1H =
    TW'(us_to_cyc(BIT_TOTAL - BIT1_LOW, CLK_PER_US) - 1);
  localparam logic [TW-1:0] T_SL =
    TW'(us_to_cyc(STOP_LOW, CLK_PER_US) - 1);
  localparam logic [TW-1:0] T_SH =
    TW'(us_to_cyc(STOP_HIGH, CLK_PER_US) - 1);
  localparam logic [TW-1:0] T_SA =
    TW'(us_to_cyc(SAMPLE_AT, CLK_PER_US) - 1);
  localparam logic [TW-1:0] T_TO = TW'(TO_CYC - 1);

  localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);

  state_t           state;
  logic [TW-1:0]    tick;
  logic [7:0]       tx_sr;
  logic [2:0]       bit_idx;
  logic [LEN_W-1:0] tx_left;
  logic [LEN_W-1:0] rx_len_q;
  logic [7:0]       rx_sr;
  logic [2:0]       rx_bit;
  logic             stop_fell;
  logic [TW-1:0]    low_end;
  logic [TW-1:0]    high_end;
  logic             last_bit;
  logic             more_tx;
  logic [7:0]       rx_nxt;

  logic line_lvl;
  logic line_fall;
  logic line_rise;

  n64_joybus_rx_sync u_sync (
    .clock   (clock),
    .reset_l (reset_l),
    .joy_in  (joy_in),
    .level   (line_lvl),
    .fall    (line_fall),
    .rise    (line_rise)
  );

  assign last_bit = (bit_idx == 3'd0);
  assign more_tx  = (tx_left != '0);
  assign rx_nxt   = {rx_sr[6:0], line_lvl};

  // the TX_LOAD cycle is borrowed from the previous bit's high time
  // so back-to-back bytes keep an exact 4 us bit period
  always_comb begin
    low_end  = tx_sr[7] ? T_B1L : T_B0L;
    high_end = tx_sr[7] ? T_B1H : T_B0H;
    if (last_bit && more_tx) high_end = high_end - ONE_T;
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state     <= ST_IDLE;
      tick      <= '0;
      tx_sr     <= '0;
      bit_idx   <= '0;
      tx_left   <= '0;
      rx_len_q  <= '0;
      rx_sr     <= '0;
      rx_bit    <= '0;
      stop_fell <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      timeout   <= 1'b0;
      rx_count  <= '0;
    end else begin
      rx_valid <= 1'b0;
      tick     <= tick + ONE_T;
      unique case (state)
        ST_IDLE: begin
          tick <= '0;
          if (start) begin
            tx_left  <= tx_len;
            rx_len_q <= rx_len;
            rx_count <= '0;
            timeout  <= 1'b0;
            state    <= ST_TX_LOAD;
          end
        end
        ST_TX_LOAD: begin
          tx_sr   <= tx_data;
          bit_idx <= 3'd7;
          tx_left <= tx_left - ONE_L;
          tick    <= '0;
          state   <= ST_TX_LOW;
        end
        ST_TX_LOW: begin
          if (tick == low_end) begin
            tick  <= '0;
            state <= ST_TX_HIGH;
          end
        end
        ST_TX_HIGH: begin
          if (tick == high_end) begin
            tick <= '0;
            if (!last_bit) begin
              tx_sr   <= {tx_sr[6:0], 1'b0};
              bit_idx <= bit_idx - 3'd1;
              state   <= ST_TX_LOW;
            end else if (more_tx) begin
              state <= ST_TX_LOAD;
            end else begin
              state <= ST_STOP_LOW;
            end
          end
        end
        ST_STOP_LOW: begin
          if (tick == T_SL) begin
            tick  <= '0;
            state <= ST_STOP_HIGH;
          end
        end
        ST_STOP_HIGH: begin
          if (tick == T_SH) begin
            tick   <= '0;
            rx_bit <= '0;
            state  <= (rx_len_q == '0) ? ST_FIN
                                       : ST_RX_WAIT;
          end
        end
        ST_RX_WAIT: begin
          if (line_fall) begin
            tick  <= '0;
            state <= ST_RX_SAMPLE;
          end else if (tick == T_TO) begin
            timeout <= 1'b1;
            state   <= ST_FIN;
          end
        end
        ST_RX_SAMPLE: begin
          if (tick == T_SA) begin
            rx_sr  <= rx_nxt;
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) begin
              rx_data  <= rx_nxt;
              rx_valid <= 1'b1;
              rx_count <= rx_count + ONE_L;
            end
            tick  <= '0;
            state <= ST_RX_RISE;
          end
        end
        ST_RX_RISE: begin
          if (line_lvl) begin
            tick      <= '0;
            stop_fell <= 1'b0;
            state     <= (rx_count == rx_len_q) ? ST_RX_STOP
                                                : ST_RX_WAIT;
          end else if (tick == T_TO) begin
            timeout <= 1'b1;
            state   <= ST_FIN;
          end
        end
        ST_RX_STOP: begin
          if (line_rise && stop_fell) begin
            state <= ST_FIN;
          end else if (line_fall) begin
            stop_fell <= 1'b1;
          end else if (tick == T_TO) begin
            timeout <= 1'b1;
            state   <= ST_FIN;
          end
        end
        ST_FIN: begin
          tick  <= '0;
          state <= ST_IDLE;
        end
        default: begin
          tick  <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_rd  = (state == ST_TX_LOAD);
  assign done   = (state == ST_FIN);
  assign busy   = (state != ST_IDLE) && (state != ST_FIN);
  assign joy_oe = (state == ST_TX_LOW) || (state == ST_STOP_LOW);

endmodule

// File: tb/tb_n64_joybus_host.sv
// tb_n64_joybus_host: directed + randomized transactions against a
// behavioural device model and line-timing reference.
module tb_n64_joybus_host;
  import n64_joybus_pkg::*;

  localparam int US    = 50;
  localparam int TO_US = 100;

  logic       clock = 1'b0;
  logic       reset_l = 1'b0;
  logic       start = 1'b0;
  logic [5:0] tx_len = '0;
  logic [5:0] rx_len = '0;
  logic [7:0] tx_data;
  logic       tx_rd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [5:0] rx_count;
  logic       joy_oe;
  logic       joy_in;
  logic       dev_oe = 1'b0;
  logic       glitch = 1'b0;
  logic       clr = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] txbuf [0:7];
  logic [7:0] devbuf [0:7];
  int         rd_cnt = 0;
  int         cyc = 0;
  int         run = 0;
  logic       prev_oe = 1'b0;
  int         rel_cyc = 0;
  int         lows [$];
  int         falls [$];
  logic [7:0] rxq [$];

  assign joy_in  = ~(joy_oe | dev_oe | glitch);
  assign tx_data = txbuf[rd_cnt[2:0]];

  always #10 clock = ~clock;

  n64_joybus_host dut (
    .clock    (clock),
    .reset_l  (reset_l),
    .start    (start),
    .tx_len   (tx_len),
    .rx_len   (rx_len),
    .tx_data  (tx_data),
    .tx_rd    (tx_rd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout),
    .rx_count (rx_count),
    .joy_oe   (joy_oe),
    .joy_in   (joy_in)
  );

  always @(posedge clock) begin
    if (clr)        rd_cnt <= 0;
    else if (tx_rd) rd_cnt <= rd_cnt + 1;
  end

  always @(negedge clock) begin
    if (clr) begin
      lows.delete();
      falls.delete();
      rxq.delete();
      run <= 0;
    end else begin
      if (joy_oe) begin
        run <= run + 1;
      end else if (run != 0) begin
        lows.push_back(run);
        run <= 0;
        rel_cyc <= cyc;
      end
      if (joy_oe && !prev_oe) falls.push_back(cyc);
      if (rx_valid) rxq.push_back(rx_data);
    end
    prev_oe <= joy_oe;
    cyc <= cyc + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    @(negedge clock);
    #2 clr = 1'b1;
    @(negedge clock);
    #2 clr = 1'b0;
  endtask

  task automatic dev_bit(input logic b);
    dev_oe = 1'b1;
    repeat (b ? US : 3 * US) @(negedge clock);
    dev_oe = 1'b0;
    repeat (b ? 3 * US : US) @(negedge clock);
  endtask

  task automatic dev_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) dev_bit(b[i]);
  endtask

  task automatic dev_stop();
    dev_oe = 1'b1;
    repeat (US) @(negedge clock);
    dev_oe = 1'b0;
    repeat (2 * US) @(negedge clock);
  endtask

  task automatic dev_wait_host(input int tl, input string tag);
    int need;
    need = 8 * tl + 1;
    for (int i = 0; i < 40000 && lows.size() < need; i++)
      @(negedge clock);
    chk({tag, "_devsync"}, lows.size(), need);
    repeat (3 * US) @(negedge clock);
  endtask

  task automatic run_txn(input int tl, input int rl, input int nsend,
                         input bit dstop, input bit gl,
                         input string tag);
    bit         got;
    logic       to;
    logic [5:0] cnt;
    int         dcyc;
    int         exp_lows [$];
    logic [7:0] exp_rx [$];
    int         bad;
    bit         exp_to;
    logic [7:0] b;

    clear_mon();
    exp_lows.delete();
    for (int k = 0; k < tl; k++) begin
      b = txbuf[k];
      for (int i = 7; i >= 0; i--)
        exp_lows.push_back(b[i] ? US : 3 * US);
    end
    exp_lows.push_back(US);
    exp_rx.delete();
    for (int k = 0; k < nsend; k++) exp_rx.push_back(devbuf[k]);
`ifndef JOYBUS_GLITCH_FILTER_EN
    if (gl) exp_rx[0] = {1'b1, devbuf[0][7:1]};
`endif
    exp_to = (rl != 0) && !((nsend == rl) && dstop);

    @(negedge clock);
    tx_len = 6'(tl);
    rx_len = 6'(rl);
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1'b1);
    got = 1'b0; to = 1'bx; cnt = 'x; dcyc = 0;
    fork
      begin
        if (nsend > 0 || gl) begin
          dev_wait_host(tl, tag);
          if (gl) begin
            glitch = 1'b1;
            @(negedge clock);
            glitch = 1'b0;
            repeat (5 * US) @(negedge clock);
          end
          for (int k = 0; k < nsend; k++) dev_byte(devbuf[k]);
          if (dstop) dev_stop();
        end
      end
      begin
        for (int i = 0; i < 60000 && !got; i++) begin
          @(negedge clock);
          if (done) begin
            got  = 1'b1;
            to   = timeout;
            cnt  = rx_count;
            dcyc = cyc;
            chk({tag, "_busy_at_done"}, busy, 1'b0);
            start = 1'b1;
          end
        end
        chk({tag, "_done_seen"}, got, 1'b1);
        if (got) begin
          @(negedge clock);
          start = 1'b0;
          chk({tag, "_fin_start_ign"}, busy, 1'b0);
          @(negedge clock);
          chk({tag, "_idle"}, busy, 1'b0);
        end
      end
    join

    chk({tag, "_timeout"}, to, exp_to);
    chk({tag, "_rx_count"}, 32'(cnt), exp_rx.size());
    chk({tag, "_tx_rd_cnt"}, rd_cnt, tl);
    chk({tag, "_low_cnt"}, lows.size(), exp_lows.size());
    bad = 0;
    foreach (exp_lows[i])
      if (i >= lows.size() || lows[i] != exp_lows[i]) bad++;
    chk({tag, "_low_widths"}, bad, 0);
    bad = 0;
    for (int i = 1; i < falls.size(); i++)
      if (falls[i] - falls[i-1] != BIT_TOTAL * US) bad++;
    chk({tag, "_bit_period"}, bad, 0);
    chk({tag, "_rx_n"}, rxq.size(), exp_rx.size());
    foreach (exp_rx[i])
      chk($sformatf("%s_rx%0d", tag, i),
          (i < rxq.size()) ? 32'(rxq[i]) : 32'hxxxx, 32'(exp_rx[i]));
    if (tag == "absent") begin
      bad = dcyc - rel_cyc - (STOP_HIGH + TO_US) * US;
      chk("absent_latency", (bad >= -2 && bad <= 2), 1'b1);
    end
  endtask

  initial begin
    bit ok;
    foreach (txbuf[i]) txbuf[i] = 8'h00;
    foreach (devbuf[i]) devbuf[i] = 8'h00;

    #5;
    chk("rst_joy_oe", joy_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_tx_rd", tx_rd, 1'b0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_rx_count", rx_count, 6'd0);
    chk("rst_rx_data", rx_data, 8'h00);
    repeat (3) @(negedge clock);
    reset_l = 1'b1;
    repeat (3) @(negedge clock);

    txbuf[0] = CMD_INFO;
    devbuf[0] = 8'h05; devbuf[1] = 8'h00; devbuf[2] = 8'h02;
    run_txn(1, 3, 3, 1'b1, 1'b0, "info");

    txbuf[0] = CMD_STATE;
    devbuf[0] = 8'h80; devbuf[1] = 8'h00;
    devbuf[2] = 8'h7F; devbuf[3] = 8'h81;
    run_txn(1, 4, 4, 1'b1, 1'b0, "buttons");

    for (int t = 0; t < 4; t++) begin
      int tl;
      int rl;
      tl = $urandom_range(1, 2);
      rl = $urandom_range(0, 3);
      foreach (txbuf[i]) txbuf[i] = 8'($urandom);
      foreach (devbuf[i]) devbuf[i] = 8'($urandom);
      run_txn(tl, rl, rl, 1'b1, 1'b0, $sformatf("rand%0d", t));
    end

    txbuf[0] = CMD_INFO;
    run_txn(1, 3, 0, 1'b0, 1'b0, "absent");

    devbuf[0] = 8'($urandom);
    run_txn(1, 3, 1, 1'b0, 1'b0, "partial");

    clear_mon();
    txbuf[0] = CMD_READ;
    txbuf[1] = 8'($urandom);
    @(negedge clock);
    tx_len = 6'd2;
    rx_len = 6'd0;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clock);
      ok = (rd_cnt == 2) && joy_oe;
    end
    chk("midtx_reached", ok, 1'b1);
    #3 reset_l = 1'b0;
    #1;
    chk("midtx_joy_oe", joy_oe, 1'b0);
    chk("midtx_busy", busy, 1'b0);
    chk("midtx_done", done, 1'b0);
    repeat (3) @(negedge clock);
    reset_l = 1'b1;
    repeat (2) @(negedge clock);
    txbuf[0] = CMD_RESET;
    run_txn(1, 0, 0, 1'b0, 1'b0, "post_rst");

    txbuf[0] = CMD_INFO;
    devbuf[0] = 8'($urandom);
    run_txn(1, 1, 1, 1'b1, 1'b1, "glitch");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
